// File: rtl/serv_lsu_pkg.sv
// Shared encodings and helpers for the serial load/store unit.
package serv_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {S_IDLE, S_BUS} state_e;

  // Folds the reserved size 11 into a word access.
  function automatic logic [1:0] lsu_size(input logic [1:0] funct3_size);
    lsu_size = (funct3_size == 2'b11) ? SZ_WORD : funct3_size;
  endfunction

  function automatic logic [3:0] lsu_sel(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: lsu_sel = 4'b0001 << lsb;
      SZ_HALF: lsu_sel = lsb[1] ? 4'b1100 : 4'b0011;
      default: lsu_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    lsu_misaligned = ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/serv_lsu_align.sv
// Shifts the bus read word down to the addressed lane and sign/zero-extends it.
module serv_lsu_align
  import serv_lsu_pkg::*;
(
  input  logic [31:0] rdt_i,
  input  logic [1:0]  lsb_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  always_comb begin
    lane = rdt_i >> {lsb_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_i & lane[7]}}, lane[7:0]};
      SZ_HALF: data_o = {{16{sign_i & lane[15]}}, lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/serv_lsu.sv
// Serial load/store unit: shifts store data in, runs one data-bus cycle, shifts load data out.
module serv_lsu
  import serv_lsu_pkg::*;
#(
  parameter int unsigned W = 1,
  parameter int unsigned B = W - 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_adr,
  input  logic [1:0]  i_lsb,
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic        i_req,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_misalign,
  input  logic        i_rs2_en,
  input  logic [B:0]  i_rs2,
  input  logic        i_rd_en,
  output logic [B:0]  o_rd,
  output logic [31:0] o_dbus_adr,
  output logic [31:0] o_dbus_dat,
  output logic [3:0]  o_dbus_sel,
  output logic        o_dbus_we,
  output logic        o_dbus_cyc,
  input  logic [31:0] i_dbus_rdt,
  input  logic        i_dbus_ack
);

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  lsb_q, lsb_d;
  logic [31:0] sdat_q, sdat_d;
  logic [31:0] ldat_q, ldat_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;

  logic [1:0]  req_size;
  logic [31:0] ld_word;
  logic        unused_adr;

  assign unused_adr = ^i_adr[1:0];
  assign req_size   = lsu_size(i_funct3[1:0]);

  serv_lsu_align u_align (
    .rdt_i  (i_dbus_rdt),
    .lsb_i  (lsb_q),
    .size_i (size_q),
    .sign_i (sign_q),
    .data_o (ld_word)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    size_d     = size_q;
    sign_d     = sign_q;
    lsb_d      = lsb_q;
    sdat_d     = sdat_q;
    ldat_d     = ldat_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rs2_en) sdat_d = {i_rs2, sdat_q[31:W]};
        if (i_rd_en)  ldat_d = {{W{1'b0}}, ldat_q[31:W]};
        if (i_req) begin
          if (lsu_misaligned(req_size, i_lsb)) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d = S_BUS;
            adr_d   = {i_adr[31:2], 2'b00};
            we_d    = i_we;
            sel_d   = lsu_sel(req_size, i_lsb);
            size_d  = req_size;
            sign_d  = ~i_funct3[2];
            lsb_d   = i_lsb;
          end
        end
      end
      S_BUS: begin
        // Shift enables are ignored here, so a capture always wins over i_rd_en.
        if (i_dbus_ack) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!we_q) ldat_d = ld_word;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      lsb_q      <= '0;
      sdat_q     <= '0;
      ldat_q     <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      lsb_q      <= lsb_d;
      sdat_q     <= sdat_d;
      ldat_q     <= ldat_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    case (size_q)
      SZ_BYTE: o_dbus_dat = {4{sdat_q[7:0]}};
      SZ_HALF: o_dbus_dat = {2{sdat_q[15:0]}};
      default: o_dbus_dat = sdat_q;
    endcase
  end

  assign o_busy     = (state_q == S_BUS);
  assign o_dbus_cyc = (state_q == S_BUS);
  assign o_dbus_we  = we_q & o_dbus_cyc;
  assign o_dbus_adr = adr_q;
  assign o_dbus_sel = sel_q;
  assign o_done     = done_q;
  assign o_misalign = misalign_q;
  assign o_rd       = i_rd_en ? ldat_q[B:0] : '0;

endmodule

// File: tb/tb_serv_lsu.sv
// Directed scoreboard bench for serv_lsu, exercising W=1 and W=4 instances side by side.
module tb_serv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [1:0]  lsb;
  logic [2:0]  funct3;
  logic        we, req, ack;
  logic [31:0] rdt;
  logic        rs2_en1, rs2_en4, rd_en1, rd_en4;
  logic [0:0]  rs2_1, rd1;
  logic [3:0]  rs2_4, rd4;

  logic        busy1, done1, mis1, dwe1, cyc1;
  logic [31:0] dadr1, ddat1;
  logic [3:0]  dsel1;
  logic        busy4, done4, mis4, dwe4, cyc4;
  logic [31:0] dadr4, ddat4;
  logic [3:0]  dsel4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  serv_lsu #(.W(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_adr(adr), .i_lsb(lsb), .i_funct3(funct3), .i_we(we),
    .i_req(req), .o_busy(busy1), .o_done(done1), .o_misalign(mis1), .i_rs2_en(rs2_en1),
    .i_rs2(rs2_1), .i_rd_en(rd_en1), .o_rd(rd1), .o_dbus_adr(dadr1), .o_dbus_dat(ddat1),
    .o_dbus_sel(dsel1), .o_dbus_we(dwe1), .o_dbus_cyc(cyc1), .i_dbus_rdt(rdt),
    .i_dbus_ack(ack)
  );

  serv_lsu #(.W(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_adr(adr), .i_lsb(lsb), .i_funct3(funct3), .i_we(we),
    .i_req(req), .o_busy(busy4), .o_done(done4), .o_misalign(mis4), .i_rs2_en(rs2_en4),
    .i_rs2(rs2_4), .i_rd_en(rd_en4), .o_rd(rd4), .o_dbus_adr(dadr4), .o_dbus_dat(ddat4),
    .o_dbus_sel(dsel4), .o_dbus_we(dwe4), .o_dbus_cyc(cyc4), .i_dbus_rdt(rdt),
    .i_dbus_ack(ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic shift_out1(output logic [31:0] v);
    rd_en1 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1 v[i] = rd1[0];
      tick();
    end
    rd_en1 = 1'b0;
  endtask

  task automatic shift_out4(output logic [31:0] v);
    rd_en4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 v[4*i +: 4] = rd4;
      tick();
    end
    rd_en4 = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] l,
                         input logic [2:0] f3, input logic [31:0] r, input logic [3:0] esel,
                         input logic [31:0] eval);
    logic [31:0] v;
    adr = a; lsb = l; funct3 = f3; we = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    check({tag, "_cyc"}, {31'd0, cyc1}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy1}, 32'd1);
    check({tag, "_adr"}, dadr1, a & ~32'd3);
    check({tag, "_sel"}, {28'd0, dsel1}, {28'd0, esel});
    check({tag, "_we"}, {31'd0, dwe1}, 32'd0);
    tick();
    tick();
    check({tag, "_cyc_hold"}, {31'd0, cyc1}, 32'd1);
    rdt = r; ack = 1'b1;
    sb_push({tag, "_rd1"}, eval);
    sb_push({tag, "_rd4"}, eval);
    tick();
    ack = 1'b0; rdt = $urandom;
    check({tag, "_done"}, {31'd0, done1}, 32'd1);
    check({tag, "_done4"}, {31'd0, done4}, 32'd1);
    check({tag, "_mis"}, {31'd0, mis1}, 32'd0);
    check({tag, "_cyc_off"}, {31'd0, cyc1}, 32'd0);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done1}, 32'd0);
    check({tag, "_rd_gate"}, {31'd0, rd1}, 32'd0);
    shift_out1(v);
    sb_check(v);
    shift_out4(v);
    sb_check(v);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [1:0] l,
                          input logic [2:0] f3, input logic [31:0] rs2, input logic [31:0] edat,
                          input logic [3:0] esel);
    logic [31:0] sh;
    for (int i = 0; i < 32; i++) begin
      sh      = rs2 >> (4 * i);
      rs2_1   = rs2[i];
      rs2_en1 = 1'b1;
      rs2_en4 = (i < 8);
      rs2_4   = sh[3:0];
      tick();
    end
    rs2_en1 = 1'b0; rs2_en4 = 1'b0;
    sb_push({tag, "_dat1"}, edat);
    sb_push({tag, "_dat4"}, edat);
    adr = a; lsb = l; funct3 = f3; we = 1'b1; req = 1'b1;
    tick();
    req = 1'b0; we = 1'b0;
    sb_check(ddat1);
    sb_check(ddat4);
    check({tag, "_sel"}, {28'd0, dsel1}, {28'd0, esel});
    check({tag, "_we"}, {31'd0, dwe1}, 32'd1);
    check({tag, "_cyc"}, {31'd0, cyc1}, 32'd1);
    repeat (3) tick();
    check({tag, "_we_hold"}, {31'd0, dwe1}, 32'd1);
    check({tag, "_we4_hold"}, {31'd0, dwe4}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_done"}, {31'd0, done1}, 32'd1);
    check({tag, "_we_off"}, {31'd0, dwe1}, 32'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; adr = '0; lsb = '0; funct3 = '0; we = 1'b0; req = 1'b0; ack = 1'b0;
    rdt = '0; rs2_en1 = 1'b0; rs2_en4 = 1'b0; rd_en1 = 1'b0; rd_en4 = 1'b0;
    rs2_1 = '0; rs2_4 = '0;
    tick();
    tick();
    check("rst_cyc", {31'd0, cyc1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_mis", {31'd0, mis1}, 32'd0);
    check("rst_we", {31'd0, dwe1}, 32'd0);
    check("rst_adr", dadr1, 32'd0);
    check("rst_sel", {28'd0, dsel1}, 32'd0);
    check("rst_dat", ddat1, 32'd0);
    rst = 1'b0;
    tick();

    do_load("lb", 32'h2000_1237, 2'b01, 3'b000, 32'h1234_8056, 4'b0010, 32'hFFFF_FF80);
    do_load("lhu", 32'h0000_0402, 2'b10, 3'b101, 32'h8001_0000, 4'b1100, 32'h0000_8001);
    do_load("lbu", 32'h0000_0010, 2'b11, 3'b100, 32'hF3AA_BBCC, 4'b1000, 32'h0000_00F3);
    do_store("sw", 32'h1000_0000, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
    do_store("sb", 32'h1000_0013, 2'b11, 3'b000, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000);
    do_store("sh", 32'h1000_0022, 2'b10, 3'b001, 32'h1234_5678, 32'h5678_5678, 4'b1100);

    // Misaligned lw and lh never raise a bus cycle.
    for (int k = 0; k < 2; k++) begin
      lsb = (k == 0) ? 2'b10 : 2'b11;
      funct3 = (k == 0) ? 3'b010 : 3'b001;
      adr = 32'h3000_0000; req = 1'b1;
      tick();
      req = 1'b0;
      check("mis_cyc", {31'd0, cyc1}, 32'd0);
      check("mis_done", {31'd0, done1}, 32'd1);
      check("mis_flag", {31'd0, mis1}, 32'd1);
      tick();
      check("mis_done_pulse", {31'd0, done1}, 32'd0);
      check("mis_flag_pulse", {31'd0, mis1}, 32'd0);
    end

    // Second request during BUS must not disturb the outstanding lw.
    adr = 32'h4000_0100; lsb = 2'b00; funct3 = 3'b010; we = 1'b0; req = 1'b1;
    tick();
    adr = 32'h5555_0000; lsb = 2'b11; funct3 = 3'b000; we = 1'b1;
    tick();
    req = 1'b0; we = 1'b0;
    check("req2_adr", dadr1, 32'h4000_0100);
    check("req2_we", {31'd0, dwe1}, 32'd0);
    check("req2_sel", {28'd0, dsel1}, 32'h0000_000F);
    rdt = 32'hCAFE_F00D; ack = 1'b1;
    sb_push("lw_rd1", 32'hCAFE_F00D);
    tick();
    ack = 1'b0;
    check("req2_done", {31'd0, done1}, 32'd1);
    tick();
    shift_out1(v);
    sb_check(v);

    // Stray ack while idle.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("stray_done", {31'd0, done1}, 32'd0);
    check("stray_cyc", {31'd0, cyc1}, 32'd0);
    tick();
    check("stray_done2", {31'd0, done1}, 32'd0);

    // Reset while the bus cycle waits on a late ack.
    adr = 32'h6000_0000; lsb = 2'b00; funct3 = 3'b010; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    check("rstmid_cyc_pre", {31'd0, cyc1}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_cyc", {31'd0, cyc1}, 32'd0);
    check("rstmid_busy", {31'd0, busy1}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("rstmid_done", {31'd0, done1}, 32'd0);
    tick();
    check("rstmid_done2", {31'd0, done1}, 32'd0);

    check("sb_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serv_lsu.md
Name: serv_lsu

Overview:
- Load/store unit directly downstream of the bit-serial buffer register.
- Inputs:
  - the word-aligned data-bus address and the two address LSBs from the buffer register;
  - store data (rs2), shifted in serially.
- Runs one 32-bit Wishbone-style data-bus transaction per request.
- Returns load data aligned and sign/zero-extended, shifted out serially to the rd writeback path W bits per step.

Parameters:
- W, 1, serial datapath width in bits; legal values 1 and 4.
- B, W-1, derived MSB index of the serial ports; not overridden.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_adr  input  32  word address from the buffer register; bits [1:0] ignored.
- i_lsb  input  2  byte offset from the buffer register.
- i_funct3  input  3  [1:0] size (00 byte, 01 half, 10 word); [2] = 1 means unsigned load.
- i_we  input  1  1 = store, 0 = load; sampled with i_req.
- i_req  input  1  single-cycle start pulse.
- o_busy  output  1  high while the bus cycle is outstanding.
- o_done  output  1  one-cycle completion pulse.
- o_misalign  output  1  qualifies o_done; high means the access was aborted as misaligned.
- i_rs2_en  input  1  shift-in enable for store data.
- i_rs2  input  W  store data, LSB-first.
- i_rd_en  input  1  shift-out enable for load data.
- o_rd  output  W  load data, LSB-first.
- o_dbus_adr  output  32  bus address, bits [1:0] = 00.
- o_dbus_dat  output  32  bus write data.
- o_dbus_sel  output  4  byte enables.
- o_dbus_we  output  1  bus write strobe.
- o_dbus_cyc  output  1  bus cycle valid.
- i_dbus_rdt  input  32  bus read data.
- i_dbus_ack  input  1  bus acknowledge; valid only while o_dbus_cyc is high.

Behaviour:
- Reset (asynchronous): FSM goes to IDLE; o_dbus_cyc, o_dbus_we, o_busy, o_done and o_misalign are 0; sdat, ldat, latched address, sel and size are 0.
- Reset mid-transaction: o_dbus_cyc drops immediately, no o_done is produced, and any later ack is ignored.
- FSM states: IDLE and BUS.
- IDLE with i_req, access aligned:
  - latch {i_adr[31:2],00}, i_we, sel, size, sign and lsb;
  - go to BUS; o_dbus_cyc = 1 from the next cycle (latency 1).
- IDLE with i_req, access misaligned:
  - stay in IDLE with no bus cycle;
  - the next cycle gives o_done = 1 and o_misalign = 1.
  - Misaligned means half with lsb[0] = 1, or word with lsb != 00.
- BUS with i_dbus_ack:
  - go to IDLE, o_dbus_cyc = 0;
  - the next cycle gives o_done = 1 and o_misalign = 0;
  - on a load, ldat is captured on the ack edge.
- i_req while in BUS is ignored.
- i_dbus_ack while in IDLE is ignored.
- o_busy = (state == BUS).
- Size 11 is treated as word.
- Store shift, IDLE only: when i_rs2_en, sdat <= {i_rs2, sdat[31:W]}. After 32/W enables, sdat holds rs2. i_rs2_en is ignored in BUS.
- Write data replication:
  - byte: {4{sdat[7:0]}};
  - half: {2{sdat[15:0]}};
  - word: sdat.
- o_dbus_sel:
  - byte: 0001 << lsb;
  - half: lsb[1] ? 1100 : 0011;
  - word: 1111.
- o_dbus_adr and o_dbus_sel hold their latched values; o_dbus_we = latched we & o_dbus_cyc.
- Load alignment at ack:
  - r = i_dbus_rdt >> (8*lsb);
  - byte: {24{s & r[7]}, r[7:0]};
  - half: {16{s & r[15]}, r[15:0]};
  - word: r;
  - s = ~funct3[2].
- Load shift:
  - o_rd = ldat[B:0] when i_rd_en, else 0;
  - when i_rd_en in IDLE, ldat <= {W'b0, ldat[31:W]};
  - no shift in BUS.
- An ack and an i_rd_en in the same cycle: the capture wins.

Decomposition:
- Shared package serv_lsu_pkg:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - state encoding S_IDLE / S_BUS;
  - function for the sel computation.
- One natural combinational sub-module, serv_lsu_align: inputs rdt, lsb, size, signed; output the extended 32-bit word.

Test Plan:
- Load, lb, signed: lsb = 01, rdt 0x12_34_80_56 -> sel 0010, o_dbus_adr = i_adr & ~3, o_done 1 cycle after ack, 32 serial bits = 0xFFFFFF80.
- Load, lhu: lsb = 10, rdt 0x8001_0000 -> sel 1100, result 0x00008001.
- Store, sw: rs2 0xDEADBEEF shifted in with W = 1 and again with W = 4, lsb = 00 -> o_dbus_dat 0xDEADBEEF, sel 1111, we 1; o_dbus_we/o_dbus_cyc stay high until ack.
- Store, sb: lsb = 11, rs2 0x000000A5 -> dat 0xA5A5A5A5, sel 1000.
- Misaligned: lw with lsb = 10 -> no o_dbus_cyc, o_done = o_misalign = 1 for one cycle.
- Robustness:
  - ack held off 5 cycles, then reset asserted -> o_dbus_cyc 0 immediately, no o_done;
  - second i_req during BUS is ignored;
  - stray ack in IDLE is ignored.
